// File: rtl/clusterv_project_wrapper.sv
// Cluster-V user-project wrapper: Wishbone register file driving GPIO, LA, timer and IRQs.
// Ack one cycle after request, never stalls; held strobe acks every other cycle.
module clusterv_project_wrapper #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_PADS   = 38,
  parameter logic [31:0] ID_VALUE  = 32'h434C_5356
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [127:0]         la_data_in,
  output logic [127:0]         la_data_out,
  input  logic [127:0]         la_oenb,
  input  logic [IO_PADS-1:0]   io_in,
  output logic [IO_PADS-1:0]   io_out,
  output logic [IO_PADS-1:0]   io_oeb,
  inout  wire  [IO_PADS-10:0]  analog_io,
  input  logic                 user_clock2,
  output logic [2:0]           user_irq
);

  localparam int HI_W = IO_PADS - 32;

  logic            req, hit, wr_en;
  logic [5:0]      idx;
  logic [31:0]     bmask, rd_mux, wr_merged, wr_bits;
  logic [31:0]     scratch, timer_cmp, timer_cnt;
  logic [1:0]      timer_ctrl;
  logic [2:0]      irq_en, irq_status, irq_status_nxt;
  logic [3:0][31:0] la_out;
  logic [IO_PADS-1:0] io_sync1, io_sync2;
  logic            io0_prev, io0_rise, timer_match;
  logic            unused_ok;

  assign req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign hit   = wbs_adr_i[31:24] == BASE_ADDR[31:24];
  assign idx   = wbs_adr_i[7:2];
  assign wr_en = req & hit & wbs_we_i;
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // RW registers read back their own value, so the mux doubles as the byte-merge base.
  assign wr_merged = (rd_mux & ~bmask) | (wbs_dat_i & bmask);
  assign wr_bits   = wbs_dat_i & bmask;
  assign la_data_out = la_out;

  assign timer_match = timer_ctrl[0] && (timer_cnt == timer_cmp);
  assign io0_rise    = io_sync2[0] & ~io0_prev;

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (idx)
        6'd0:  rd_mux = ID_VALUE;
        6'd1:  rd_mux = scratch;
        6'd2:  rd_mux = io_out[31:0];
        6'd3:  rd_mux = 32'(io_out[IO_PADS-1:32]);
        6'd4:  rd_mux = io_oeb[31:0];
        6'd5:  rd_mux = 32'(io_oeb[IO_PADS-1:32]);
        6'd6:  rd_mux = io_sync2[31:0];
        6'd7:  rd_mux = 32'(io_sync2[IO_PADS-1:32]);
        6'd8, 6'd9, 6'd10, 6'd11:  rd_mux = la_out[idx[1:0]];
        6'd12, 6'd13, 6'd14, 6'd15: rd_mux = la_data_in[{idx[1:0], 5'd0} +: 32];
        6'd16, 6'd17, 6'd18, 6'd19: rd_mux = la_oenb[{idx[1:0], 5'd0} +: 32];
        6'd20: rd_mux = 32'(irq_en);
        6'd21: rd_mux = 32'(irq_status);
        6'd23: rd_mux = timer_cmp;
        6'd24: rd_mux = timer_cnt;
        6'd25: rd_mux = 32'(timer_ctrl);
        default: rd_mux = '0;
      endcase
    end
  end

  // Hardware sets are applied after the W1C clear so a same-cycle set wins.
  always_comb begin
    irq_status_nxt = irq_status;
    if (wr_en && idx == 6'd21) irq_status_nxt = irq_status_nxt & ~wr_bits[2:0];
    if (wr_en && idx == 6'd22) irq_status_nxt = irq_status_nxt | wr_bits[2:0];
    if (timer_match) irq_status_nxt[0] = 1'b1;
    if (io0_rise)    irq_status_nxt[1] = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rd_mux : 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      io_sync1 <= '0;
      io_sync2 <= '0;
      io0_prev <= 1'b0;
    end else begin
      io_sync1 <= io_in;
      io_sync2 <= io_sync1;
      io0_prev <= io_sync2[0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      scratch    <= '0;
      io_out     <= '0;
      io_oeb     <= '1;
      la_out     <= '0;
      irq_en     <= '0;
      timer_cmp  <= '0;
      timer_ctrl <= '0;
    end else if (wr_en) begin
      case (idx)
        6'd1:  scratch <= wr_merged;
        6'd2:  io_out[31:0] <= wr_merged;
        6'd3:  io_out[IO_PADS-1:32] <= wr_merged[HI_W-1:0];
        6'd4:  io_oeb[31:0] <= wr_merged;
        6'd5:  io_oeb[IO_PADS-1:32] <= wr_merged[HI_W-1:0];
        6'd8, 6'd9, 6'd10, 6'd11: la_out[idx[1:0]] <= wr_merged;
        6'd20: irq_en <= wr_merged[2:0];
        6'd23: timer_cmp <= wr_merged;
        6'd25: timer_ctrl <= wr_merged[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      timer_cnt  <= '0;
      irq_status <= '0;
      user_irq   <= '0;
    end else begin
      if (wr_en && idx == 6'd24)
        timer_cnt <= wr_merged;
      else if (timer_ctrl[0])
        timer_cnt <= (timer_match && timer_ctrl[1]) ? 32'h0 : timer_cnt + 32'd1;
      irq_status <= irq_status_nxt;
      user_irq   <= irq_status & irq_en;
    end
  end

  assign unused_ok = ^{user_clock2, analog_io, wbs_adr_i[23:8], wbs_adr_i[1:0], wr_bits[31:3]};

endmodule

// File: tb/tb_clusterv_project_wrapper.sv
// Randomized self-checking bench for clusterv_project_wrapper against a register-map model.
module tb_clusterv_project_wrapper;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h434C_5356;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   wdat = '0, adr = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [127:0]  la_in = '0, la_out, la_oenb = '0;
  logic [37:0]   io_in = '0, io_out, io_oeb;
  wire  [28:0]   analog_io;
  logic          user_clock2 = 1'b0;
  logic [2:0]    user_irq;

  int n_checks = 0;
  int n_errors = 0;

  // register-map model
  logic [31:0] m_scratch, m_cmp;
  logic [37:0] m_gout, m_goeb, m_io;
  logic [31:0] m_la [4];
  logic [127:0] m_lain, m_oenb;
  int rw_list [10] = '{1, 2, 3, 4, 5, 8, 9, 10, 11, 23};

  clusterv_project_wrapper dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_data_in(la_in), .la_data_out(la_out), .la_oenb(la_oenb),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .analog_io(analog_io),
    .user_clock2(user_clock2), .user_irq(user_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd_v);
    int lat;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; rd_v = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i; rd_v = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack_latency", lat, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'h0, 4'hF, d);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    m_scratch = '0; m_cmp = '0; m_gout = '0; m_goeb = '1;
    for (int i = 0; i < 4; i++) m_la[i] = '0;
  endfunction

  function automatic void model_write(input int i, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    case (i)
      1: m_scratch = merge(m_scratch, d, s);
      2: m_gout[31:0] = merge(m_gout[31:0], d, s);
      3: begin t = merge({26'h0, m_gout[37:32]}, d, s); m_gout[37:32] = t[5:0]; end
      4: m_goeb[31:0] = merge(m_goeb[31:0], d, s);
      5: begin t = merge({26'h0, m_goeb[37:32]}, d, s); m_goeb[37:32] = t[5:0]; end
      8, 9, 10, 11: m_la[i-8] = merge(m_la[i-8], d, s);
      23: m_cmp = merge(m_cmp, d, s);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input int i);
    case (i)
      0: return ID;
      1: return m_scratch;
      2: return m_gout[31:0];
      3: return {26'h0, m_gout[37:32]};
      4: return m_goeb[31:0];
      5: return {26'h0, m_goeb[37:32]};
      6: return m_io[31:0];
      7: return {26'h0, m_io[37:32]};
      8, 9, 10, 11: return m_la[i-8];
      12, 13, 14, 15: return m_lain[(i-12)*32 +: 32];
      16, 17, 18, 19: return m_oenb[(i-16)*32 +: 32];
      23: return m_cmp;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_pins(input string tag);
    check({tag, "_io_out"}, io_out, m_gout);
    check({tag, "_io_oeb"}, io_oeb, m_goeb);
    check({tag, "_la_out"}, la_out, {m_la[3], m_la[2], m_la[1], m_la[0]});
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] r64;
    int k, idx, op;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_irq", user_irq, 0);
    check_pins("rst");
    @(negedge clk) rst_n = 1'b1;

    rd(BASE, d);
    check("id", d, ID);
    check("id_io_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    check("id_io_out", io_out, 0);

    wr(BASE + 32'h04, 32'hDEADBEEF, 4'b0101);
    rd(BASE + 32'h04, d);
    check("scratch_sel", d, 32'h00AD00EF);
    m_scratch = 32'h00AD00EF;

    wr(BASE + 32'h08, 32'hA5A5A5A5, 4'hF);
    wr(BASE + 32'h0C, 32'h2A, 4'hF);
    wr(BASE + 32'h10, 32'h0, 4'hF);
    check("gpio_out", io_out, 38'h2A_A5A5A5A5);
    check("gpio_oeb", io_oeb, 38'h3F_0000_0000);
    io_in = 38'h15_1234_5678;
    repeat (3) @(posedge clk);
    rd(BASE + 32'h18, d);
    check("gpio_in_lo", d, 32'h12345678);
    rd(BASE + 32'h1C, d);
    check("gpio_in_hi", d, 32'h15);

    wr(BASE + 32'h2C, 32'h8000_0001, 4'hF);
    check("la_out127", la_out[127], 1);
    check("la_out96", la_out[96], 1);
    check("la_out_lo", la_out[95:0], 0);
    la_in = 128'h1;
    la_oenb = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
    rd(BASE + 32'h30, d);
    check("la_in0", d, 1);
    rd(BASE + 32'h44, d);
    check("la_oenb1", d, 32'hCAFE_F00D);

    rd(32'h2000_0000, d);
    check("out_of_region", d, 0);
    rd(BASE + 32'hFC, d);
    check("unmapped", d, 0);
    wr(32'h2000_0004, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'h04, d);
    check("oor_write_ignored", d, 32'h00AD00EF);
    rd(BASE + 32'h58, d);
    check("irq_set_reads0", d, 0);

    // held strobe: ack on every other edge
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check("held_ack", ack, (i % 2));
    end
    cyc = 1'b0; stb = 1'b0;

    // timer with auto-reload
    wr(BASE + 32'h5C, 32'd10, 4'hF);
    wr(BASE + 32'h50, 32'd1, 4'hF);
    wr(BASE + 32'h64, 32'd3, 4'hF);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (user_irq[0]) begin k = i; break; end
    end
    check("timer_irq_window", (k >= 10 && k <= 14), 1);
    rd(BASE + 32'h60, d);
    check("timer_reloaded", (d < 32'd10), 1);
    rd(BASE + 32'h54, d);
    check("timer_status", d[0], 1);
    wr(BASE + 32'h64, 32'd0, 4'hF);
    wr(BASE + 32'h54, 32'd1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("timer_irq_cleared", user_irq, 0);
    rd(BASE + 32'h54, d);
    check("status_w1c", d, 0);

    // io_in[0] rising edge, software set, enable mask
    io_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    rd(BASE + 32'h54, d);
    check("io_rise_status", d, 32'h2);
    wr(BASE + 32'h58, 32'h4, 4'hF);
    rd(BASE + 32'h54, d);
    check("irq_set_status", d, 32'h6);
    wr(BASE + 32'h50, 32'h4, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("irq_masked", user_irq, 3'b100);
    wr(BASE + 32'h54, 32'h6, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("irq_w1c_all", user_irq, 0);

    // reset in the middle of a transfer
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    @(posedge clk); #1;
    check("midrst_ack_before", ack, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ack_drop", ack, 0);
    check("midrst_dat", rdat, 0);
    model_reset();
    check_pins("midrst");
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rd(BASE + 32'h04, d);
    check("midrst_scratch", d, 0);

    // randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      r64 = {$urandom(), $urandom()};
      io_in = r64[37:0];
      la_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      la_oenb = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_io = io_in; m_lain = la_in; m_oenb = la_oenb;
      repeat (3) @(posedge clk);
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        idx = rw_list[$urandom_range(0, 9)];
        d = $urandom();
        k = $urandom_range(0, 15);
        wr(BASE | (idx << 2), d, k[3:0]);
        model_write(idx, d, k[3:0]);
        check_pins("rnd_wr");
      end else if (op == 2) begin
        do idx = $urandom_range(0, 63);
        while (idx == 20 || idx == 21 || idx == 24 || idx == 25);
        rd(BASE | (idx << 2), d);
        check($sformatf("rnd_rd_%0d", idx), d, exp_read(idx));
      end else begin
        k = $urandom_range(0, 255);
        if (k == 8'h30) k = 8'h31;
        idx = rw_list[$urandom_range(0, 9)];
        wr({k[7:0], 22'h0, idx[5:0], 2'b00}, $urandom(), 4'hF);
        check_pins("rnd_oor_wr");
        rd({k[7:0], 22'h0, idx[5:0], 2'b00}, d);
        check("rnd_oor_rd", d, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
